// File: rtl/seq_stream_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | seq_stream_gen: MSB-first serial stimulus source with "101" tracker.     |
// | Optional even-parity trailer bit: SEQ_GEN_PARITY_EN.                     |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module seq_stream_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int                BC_W      = $clog2(NBITS);
  localparam logic [BC_W-1:0]   C_LAST    = BC_W'(NBITS - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2} trk_t;

  state_t             state, state_n;
  trk_t               trk, trk_n;
  logic [NBITS-1:0]   sreg, sreg_n;
  logic [BC_W-1:0]    bcnt, bcnt_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               ready_n, valid_n, done_n;
  logic [NBITS-1:0]   load_word;

`ifdef SEQ_GEN_PARITY_EN
  assign load_word = {din, ^din};
`else
  assign load_word = din;
`endif

  // The shifter drains to zero after the last bit, so its MSB is a clean
  // registered serial output that already reads 0 in IDLE and DONE.
  assign x_out = sreg[NBITS-1];

  always_comb begin
    state_n = state;
    trk_n   = trk;
    sreg_n  = sreg;
    bcnt_n  = bcnt;
    cnt_n   = match_cnt;
    case (state)
      S_IDLE: begin
        if (load) begin
          state_n = S_SHIFT;
          sreg_n  = load_word;
          bcnt_n  = C_LAST;
          cnt_n   = '0;
          trk_n   = T0;
        end
      end
      S_SHIFT: begin
        sreg_n = {sreg[NBITS-2:0], 1'b0};
        bcnt_n = bcnt - BC_W'(1);
        if (bcnt == '0) begin
          state_n = S_DONE;
        end
        case (trk)
          T0: trk_n = x_out ? T1 : T0;
          T1: trk_n = x_out ? T1 : T2;
          T2: begin
            trk_n = x_out ? T1 : T0;
            if (x_out && (match_cnt != C_CNT_MAX)) begin
              cnt_n = match_cnt + CNT_W'(1);
            end
          end
          default: trk_n = T0;
        endcase
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    ready_n = (state_n == S_IDLE);
    valid_n = (state_n == S_SHIFT);
    done_n  = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      trk       <= T0;
      sreg      <= '0;
      bcnt      <= '0;
      match_cnt <= '0;
      ready     <= 1'b1;
      x_valid   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      trk       <= trk_n;
      sreg      <= sreg_n;
      bcnt      <= bcnt_n;
      match_cnt <= cnt_n;
      ready     <= ready_n;
      x_valid   <= valid_n;
      done      <= done_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_gen.sv
`default_nettype none
// Bench for seq_stream_gen: two instances (8-bit/4-bit count, 16-bit/2-bit count)
// checked every cycle against a stream-level model plus directed literals.
module tb_seq_stream_gen;

`ifdef SEQ_GEN_PARITY_EN
  localparam int PAR = 1;
  localparam logic [16:0] E_T1   = 17'b101011011;
  localparam logic [16:0] E_FF   = 17'b111111110;
  localparam logic [16:0] E_AA   = 17'b101010100;
  localparam logic [16:0] E_AAAA = {16'hAAAA, 1'b0};
  localparam logic [16:0] E_5A   = {8'h5A, 1'b0};
`else
  localparam int PAR = 0;
  localparam logic [16:0] E_T1   = 17'h000AD;
  localparam logic [16:0] E_FF   = 17'h000FF;
  localparam logic [16:0] E_AA   = 17'h000AA;
  localparam logic [16:0] E_AAAA = 17'h0AAAA;
  localparam logic [16:0] E_5A   = 17'h0005A;
`endif
  localparam int W0 = 8,  C0 = 4, NB0 = W0 + PAR;
  localparam int W1 = 16, C1 = 2, NB1 = W1 + PAR;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load0 = 1'b0, load1 = 1'b0;
  logic [W0-1:0] din0 = '0;
  logic [W1-1:0] din1 = '0;
  logic ready0, x_out0, x_valid0, done0;
  logic ready1, x_out1, x_valid1, done1;
  logic [C0-1:0] mc0;
  logic [C1-1:0] mc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_stream_gen #(.WIDTH(W0), .CNT_W(C0)) dut0 (
    .clk(clk), .reset(reset), .load(load0), .din(din0),
    .ready(ready0), .x_out(x_out0), .x_valid(x_valid0), .done(done0), .match_cnt(mc0));

  seq_stream_gen #(.WIDTH(W1), .CNT_W(C1)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .din(din1),
    .ready(ready1), .x_out(x_out1), .x_valid(x_valid1), .done(done1), .match_cnt(mc1));

  // Model: phase 0 = idle, 1..NB = stream bit phase-1 on the wire, NB+1 = done.
  int wv   [2] = '{W0, W1};
  int nbv  [2] = '{NB0, NB1};
  int smax [2] = '{(1 << C0) - 1, (1 << C1) - 1};
  int ph   [2] = '{0, 0};
  int hold [2] = '{0, 0};
  bit sb   [2][17];

  function automatic int cnt101(input int inst, input int n);
    int c = 0;
    for (int j = 2; j < n; j++)
      if (sb[inst][j-2] && !sb[inst][j-1] && sb[inst][j]) c++;
    return (c > smax[inst]) ? smax[inst] : c;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        ph[i]   <= 0;
        hold[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic        ld;
        logic [16:0] d;
        ld = (i == 0) ? load0 : load1;
        d  = (i == 0) ? {9'b0, din0} : {1'b0, din1};
        if (ph[i] == 0) begin
          if (ld) begin
            for (int j = 0; j < wv[i]; j++) sb[i][j] <= d[wv[i]-1-j];
            if (PAR == 1) sb[i][wv[i]] <= ^d;
            ph[i]   <= 1;
            hold[i] <= 0;
          end
        end else if (ph[i] <= nbv[i]) begin
          ph[i] <= ph[i] + 1;
        end else begin
          hold[i] <= cnt101(i, nbv[i]);
          ph[i]   <= 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int p, n, e_mc;
      p = ph[i];
      n = nbv[i];
      e_mc = (p == 0) ? hold[i] : cnt101(i, (p - 1 < n) ? p - 1 : n);
      chk($sformatf("ready%0d", i),   (i == 0) ? ready0 : ready1, (p == 0) ? 1 : 0);
      chk($sformatf("x_valid%0d", i), (i == 0) ? x_valid0 : x_valid1, (p >= 1 && p <= n) ? 1 : 0);
      chk($sformatf("x_out%0d", i),   (i == 0) ? x_out0 : x_out1,
          (p >= 1 && p <= n) ? int'(sb[i][p-1]) : 0);
      chk($sformatf("done%0d", i),    (i == 0) ? done0 : done1, (p == n + 1) ? 1 : 0);
      chk($sformatf("match_cnt%0d", i), (i == 0) ? int'(mc0) : int'(mc1), e_mc);
    end
  end

  // Call at a negedge in an idle cycle; returns at the negedge where ready is back.
  task automatic send(input int inst, input logic [16:0] d,
                      output logic [16:0] bits, output int mc, output int dn);
    bits = '0;
    if (inst == 0) begin load0 = 1'b1; din0 = d[W0-1:0]; end
    else           begin load1 = 1'b1; din1 = d[W1-1:0]; end
    @(negedge clk);
    load0 = 1'b0;
    load1 = 1'b0;
    for (int j = 0; j < nbv[inst]; j++) begin
      bits = {bits[15:0], (inst == 0) ? x_out0 : x_out1};
      @(negedge clk);
    end
    mc = (inst == 0) ? int'(mc0) : int'(mc1);
    dn = (inst == 0) ? int'(done0) : int'(done1);
    @(negedge clk);
  endtask

  initial begin
    logic [16:0] bits;
    int mc, dn, ndone;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready0, 1);
    chk("reset_mc", int'(mc0), 0);
    #2 reset = 1'b1;
    @(negedge clk);

    send(0, 17'hAD, bits, mc, dn);
    chk("t1_bits", int'(bits), int'(E_T1));
    chk("t1_mc", mc, 3);
    chk("t1_done", dn, 1);
    chk("t1_ready_after", ready0, 1);

    send(0, 17'h00, bits, mc, dn);
    chk("t2_zero_bits", int'(bits), 0);
    chk("t2_zero_mc", mc, 0);
    send(0, 17'hFF, bits, mc, dn);
    chk("t2_ones_bits", int'(bits), int'(E_FF));
    chk("t2_ones_mc", mc, 0);

    send(1, 17'hAAAA, bits, mc, dn);
    chk("t3_bits", int'(bits), int'(E_AAAA));
    chk("t3_mc_sat", mc, 3);
    repeat (5) @(negedge clk);
    chk("t3_mc_hold", int'(mc1), 3);

    send(0, 17'hAA, bits, mc, dn);
    chk("t4_aa_bits", int'(bits), int'(E_AA));
    chk("t4_aa_mc", mc, 3);

    // Hold load high with din churning every cycle: exactly 3 words fit.
    ndone = 0;
    load0 = 1'b1;
    for (int j = 0; j < 3 * (NB0 + 2); j++) begin
      din0 = W0'($urandom);
      @(negedge clk);
      ndone += int'(done0);
      if (j == 3 * (NB0 + 2) - 1) load0 = 1'b0;
    end
    chk("t5_words_sent", ndone, 3);
    @(negedge clk);

    load0 = 1'b1;
    din0  = 8'hA5;
    @(negedge clk);
    load0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_mc_before_reset", int'(mc0), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_ready", ready0, 1);
    chk("t6_valid", x_valid0, 0);
    chk("t6_xout", x_out0, 0);
    chk("t6_mc", int'(mc0), 0);
    chk("t6_done", done0, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("t6_no_done", done0, 0);
    send(0, 17'h5A, bits, mc, dn);
    chk("t6_5a_bits", int'(bits), int'(E_5A));
    chk("t6_5a_mc", mc, 2);
    chk("t6_5a_done", dn, 1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_stream_gen.md
# seq_stream_gen

- Serial stimulus transmitter for the "101" overlapping sequence-detector family: accepts a parallel word on a ready/load handshake and shifts it out MSB-first, one bit per clock, qualified by a valid strobe.
- A built-in tracker runs the same detection rule on the emitted bits and reports the expected match count, so the generator drives a detector and supplies its golden answer.

## Interface
- WIDTH, 8, data word width in bits (>= 3)
- CNT_W, 4, width of match counter (saturating)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- load  input  1  request to accept din; honoured only while ready=1
- din  input  WIDTH  word to transmit, MSB first
- ready  output  1  high when idle and able to accept load
- x_out  output  1  serial data bit
- x_valid  output  1  high on every cycle x_out carries a stream bit
- done  output  1  one-cycle pulse after the last bit is emitted
- match_cnt  output  CNT_W  count of overlapping "101" occurrences in the current word's stream

## Operation
- Main FSM has three states:
  - IDLE (ready=1).
  - SHIFT (ready=0, x_valid=1).
  - DONE (ready=0, done=1, exactly one cycle, then IDLE).
- IDLE: load=1 at an edge captures din into the shift register, loads the bit counter with NBITS-1, clears match_cnt and the tracker, and moves to SHIFT.
  - NBITS=WIDTH, or WIDTH+1 with parity enabled.
  - load=0 stays in IDLE.
  - load while ready=0 is ignored, with no side effects.
- SHIFT: x_out = shift register MSB. Each edge shifts left by one and decrements the counter. The edge with counter=0 moves to DONE.
- Outputs x_out, x_valid, done and ready are registered; no combinational path from inputs to outputs.
- In IDLE and DONE, x_out=0 and x_valid=0.
- Tracker: 3-state model T0/T1/T2. It updates at each edge ending a cycle with x_valid=1, using that cycle's x_out.
  - T0: 1→T1, 0→T0.
  - T1: 1→T1, 0→T2.
  - T2: 1→T1 and match_cnt+1; 0→T0.
- match_cnt saturates at 2^CNT_W-1 and never wraps. It holds its value through DONE and IDLE until the next accepted load.
- Reset asserted at any time, including mid-SHIFT, forces immediately:
  - state IDLE, tracker T0, shift register 0;
  - ready=1, x_out=0, x_valid=0, done=0, match_cnt=0.
- The interrupted word is discarded; after release the block waits in IDLE for a new load.

## Timing
- Load accepted at edge k. x_valid=1 during cycles k+1 .. k+NBITS. In cycle k+i, x_out = bit i of the stream (i=1 → din[WIDTH-1]).
- done=1 in cycle k+NBITS+1. ready returns to 1 in cycle k+NBITS+2. The earliest next accepted load is at the edge ending that cycle.
- Throughput: one word per NBITS+2 cycles.
- match_cnt lags the stream by one cycle and holds its final value from the DONE cycle onward.

## Configuration
- SEQ_GEN_PARITY_EN defined:
  - after the WIDTH data bits, one even-parity bit is emitted (XOR of din), so NBITS=WIDTH+1;
  - the parity bit is part of the stream seen by the tracker and counted in x_valid cycles.
- Not defined:
  - no parity logic; NBITS=WIDTH;
  - the stream is the data bits only.

## Test plan
1. WIDTH=8, CNT_W=4, no parity: din=8'b1010_1101, load pulse.
   - Required: x_valid for 8 cycles; x_out = 1,0,1,0,1,1,0,1; done one cycle later; match_cnt=3 in the DONE cycle; ready=1 the cycle after.
2. Same configuration, din=8'h00, then din=8'hFF.
   - Required: x_out all 0, then all 1; match_cnt=0 both times.
3. WIDTH=16, CNT_W=2: din=16'hAAAA (7 overlapping matches).
   - Required: match_cnt saturates at 3 and holds 3 through DONE and IDLE.
4. SEQ_GEN_PARITY_EN defined, WIDTH=8.
   - din=8'b1010_1101: 9 valid cycles, last bit 1, match_cnt=3.
   - din=8'b1010_1010: last bit 0, match_cnt=3.
5. Handshake: hold load=1 continuously with din changing every cycle.
   - Required: only the words present at ready=1 edges are sent, exactly 10 cycles apart (WIDTH=8).
   - Required: din changes during SHIFT do not affect x_out.
6. Reset mid-stream: assert reset after 4 bits of din=8'hA5.
   - Required: x_valid=0, x_out=0, match_cnt=0, ready=1 immediately; no done pulse.
   - Required: after release, din=8'h5A loads normally and completes in 10 cycles.
